// File: rtl/riscy_pkg.sv
// riscy_pkg: shared phase/opcode types and ALU-op membership for the RISCY controller
package riscy_pkg;
  typedef enum logic [2:0] {
    INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
  } phase_t;
  typedef enum logic [2:0] {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP} opcode_t;
  function automatic logic is_aluop(opcode_t op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction
endpackage

// File: rtl/riscy_phase_cnt.sv
// riscy_phase_cnt: 3-bit wrapping phase counter with enable and async clear
module riscy_phase_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [2:0] phase
);
  always_ff @(posedge clk or posedge rst)
    if (rst) phase <= '0;
    else if (en) phase <= phase + 3'd1;
endmodule

// File: rtl/riscy_controller.sv
// riscy_controller: eight-phase instruction sequencer with sticky halt and combinational control decode
module riscy_controller
  import riscy_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);
  logic       halted, halted_next, alu;
  logic [2:0] cnt;
  phase_t     ph;
  opcode_t    op;
  assign ph  = phase_t'(cnt);
  assign op  = opcode_t'(opcode);
  assign alu = is_aluop(op);
  // The counter is held on the same edge that latches halt, so the phase freezes at OP_ADDR
  assign halted_next = halted || (ph == OP_ADDR && op == HLT);
  riscy_phase_cnt u_cnt (.clk(clk), .rst(rst), .en(!halted_next), .phase(cnt));
  always_ff @(posedge clk or posedge rst)
    if (rst) halted <= 1'b0;
    else halted <= halted_next;
  assign phase  = cnt;
  assign sel    = ph inside {INST_ADDR, INST_FETCH, INST_LOAD, IDLE};
  assign rd     = ph inside {INST_FETCH, INST_LOAD, IDLE} || (ph inside {OP_FETCH, ALU_OP, STORE} && alu);
  assign ld_ir  = ph inside {INST_LOAD, IDLE};
  assign inc_pc = (ph == OP_ADDR && !halted) || (ph == ALU_OP && op == SKZ && zero);
  assign ld_pc  = ph inside {ALU_OP, STORE} && op == JMP;
  assign ld_ac  = ph == STORE && alu;
  assign wr     = ph == STORE && op == STO;
  assign data_e = ph inside {ALU_OP, STORE} && op == STO;
  assign halt   = halted || (ph == OP_ADDR && op == HLT);
endmodule

// File: tb/tb_riscy_controller.sv
// tb_riscy_controller: table-driven, directed and randomized checks of riscy_controller against a phase-rule model
module tb_riscy_controller;
  logic       clk = 1'b0, rst = 1'b1, zero = 1'b0;
  logic [2:0] opcode = 3'd2;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;
  int         checks = 0, errors = 0;
  int         m_ph = 0;
  bit         m_halt = 1'b0;

  riscy_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .sel(sel), .rd(rd), .ld_ir(ld_ir),
    .inc_pc(inc_pc), .ld_pc(ld_pc), .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      op;
    logic            z;
    logic [7:0][8:0] exp;
  } vec_t;

  // {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt} required in each phase, read off the phase rules
  function automatic logic [8:0] ref_out(int ph, logic [2:0] op, logic z, bit h);
    bit alu = (op >= 3'd2 && op <= 3'd5);
    bit s = 0, r = 0, li = 0, ip = 0, lp = 0, la = 0, w = 0, d = 0, hl = 0;
    if (h) return 9'h001;
    case (ph)
      0: s = 1;
      1: begin s = 1; r = 1; end
      2, 3: begin s = 1; r = 1; li = 1; end
      4: begin ip = 1; hl = (op == 3'd0); end
      5: r = alu;
      6: begin r = alu; ip = (op == 3'd1) && z; lp = (op == 3'd7); d = (op == 3'd6); end
      default: begin r = alu; la = alu; lp = (op == 3'd7); w = (op == 3'd6); d = (op == 3'd6); end
    endcase
    return {s, r, li, ip, lp, la, w, d, hl};
  endfunction

  task automatic chk(string nm, logic [11:0] req);
    logic [11:0] act = {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got phase=%0d outs=%b, expected phase=%0d outs=%b", nm, act[11:9], act[8:0], req[11:9], req[8:0]);
    end
  endtask

  task automatic chk_model(string nm);
    chk(nm, {3'(m_ph), ref_out(m_ph, opcode, zero, m_halt)});
  endtask

  task automatic tick();
    if (!rst) begin
      if (!m_halt && m_ph == 4 && opcode == 3'd0) m_halt = 1;
      else if (!m_halt) m_ph = (m_ph + 1) % 8;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    m_ph = 0;
    m_halt = 0;
    #1;
    rst = 1'b0;
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{3'd2, 1'b0, {9'h088, 9'h080, 9'h080, 9'h020, 9'h1C0, 9'h1C0, 9'h180, 9'h100}};
    tbl[1] = '{3'd6, 1'b0, {9'h006, 9'h002, 9'h000, 9'h020, 9'h1C0, 9'h1C0, 9'h180, 9'h100}};
    tbl[2] = '{3'd1, 1'b1, {9'h000, 9'h020, 9'h000, 9'h020, 9'h1C0, 9'h1C0, 9'h180, 9'h100}};
    tbl[3] = '{3'd1, 1'b0, {9'h000, 9'h000, 9'h000, 9'h020, 9'h1C0, 9'h1C0, 9'h180, 9'h100}};
    tbl[4] = '{3'd7, 1'b0, {9'h010, 9'h010, 9'h000, 9'h020, 9'h1C0, 9'h1C0, 9'h180, 9'h100}};
    #1;
    chk("reset_async", {3'd0, 9'h100});
    @(posedge clk);
    #1;
    chk("reset_held", {3'd0, 9'h100});
    rst = 1'b0;
    #1;
    chk("reset_release", {3'd0, 9'h100});
    tick();
    chk("first_clk", {3'd1, 9'h180});
    foreach (tbl[v]) begin
      rst_pulse();
      opcode = tbl[v].op;
      zero = tbl[v].z;
      for (int k = 0; k < 16; k++) begin
        #1;
        chk($sformatf("table_op%0d_z%0d_ph%0d", tbl[v].op, tbl[v].z, k % 8), {3'(k % 8), tbl[v].exp[k % 8]});
        tick();
      end
    end
    rst_pulse();
    opcode = 3'd0;
    for (int k = 0; k < 4; k++) tick();
    chk("hlt_op_addr", {3'd4, 9'h021});
    tick();
    chk("hlt_latched", {3'd4, 9'h001});
    opcode = 3'd2;
    zero = 1'b1;
    for (int k = 0; k < 22; k++) begin
      tick();
      chk("hlt_frozen", {3'd4, 9'h001});
    end
    rst = 1'b1;
    m_ph = 0;
    m_halt = 0;
    #1;
    chk("hlt_reset", {3'd0, 9'h100});
    rst = 1'b0;
    tick();
    chk("hlt_resume", {3'd1, 9'h180});
    rst_pulse();
    opcode = 3'd6;
    zero = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("sto_store", {3'd7, 9'h006});
    #3;
    rst = 1'b1;
    m_ph = 0;
    m_halt = 0;
    #1;
    chk("sto_async_rst", {3'd0, 9'h100});
    #1;
    rst = 1'b0;
    tick();
    chk("sto_after_rst", {3'd1, 9'h180});
    for (int i = 0; i < 3000; i++) begin
      opcode = ($urandom_range(0, 31) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      zero = 1'($urandom);
      #1;
      chk_model("rand");
      if ($urandom_range(0, 60) == 0 || (m_halt && $urandom_range(0, 9) == 0)) begin
        #1;
        rst = 1'b1;
        m_ph = 0;
        m_halt = 0;
        #1;
        chk_model("rand_rst");
        rst = 1'b0;
      end
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
